// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver with a byte FIFO behind a two-register memory-mapped interface
module uart_rx_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SerialIn,
  input  logic                  rdEn,
  input  logic                  wrtEn,
  input  logic                  addr,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] ReadReg,
  output logic                  rx_irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic sync1_q, sync2_q;
  logic [15:0] baud_q, baud_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic push_q, push_d, ferr_set;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q, count_d;
  logic ovr_q, ovr_d, ferr_q, ferr_d;
  logic empty, full, pop, push_ok, ovr_set, clr_ovr, clr_ferr;
  logic [8:0] status;
  logic wr_unused;
  assign wr_unused = ^{WrData[DATA_WIDTH-1:4], WrData[1:0]};
  always_ff @(posedge clk)
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= SerialIn;
      sync2_q <= sync1_q;
    end
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 16'd1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!sync2_q) state_d = START;
      end
      START:
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      DATA:
        if (baud_q == FULL_M1) begin
          baud_d         = '0;
          shift_d[idx_q] = sync2_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      STOP:
        if (baud_q == FULL_M1) begin
          baud_d   = '0;
          push_d   = sync2_q;
          ferr_set = !sync2_q;
          state_d  = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  assign empty    = count_q == '0;
  assign full     = count_q == (AW+1)'(FIFO_DEPTH);
  assign pop      = rdEn & ~addr & ~empty;
  assign push_ok  = push_q & (~full | pop);
  assign ovr_set  = push_q & full & ~pop;
  assign clr_ovr  = wrtEn & addr & WrData[2];
  assign clr_ferr = wrtEn & addr & WrData[3];
  assign count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
  assign ovr_d    = ovr_set | (ovr_q & ~clr_ovr);
  assign ferr_d   = ferr_set | (ferr_q & ~clr_ferr);
  always_ff @(posedge clk)
    if (!rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      push_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      push_q   <= push_d;
      wr_ptr_q <= wr_ptr_q + AW'(push_ok);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
    end
  always_ff @(posedge clk)
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  assign status  = {5'(count_q), ferr_q, ovr_q, full, ~empty};
  assign ReadReg = addr ? DATA_WIDTH'(status) : DATA_WIDTH'(empty ? 8'h00 : mem_q[rd_ptr_q]);
  assign rx_irq  = ~empty;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: directed plus random frames checked against a queue-based model of the receiver
module tb_uart_rx_mmio;
  logic clk = 1'b0, rst = 1'b0, SerialIn = 1'b1, rdEn = 1'b0, wrtEn = 1'b0, addr = 1'b0;
  logic [31:0] WrData = '0, ReadReg;
  logic rx_irq;
  int n_asrt = 0, n_fail = 0;
  byte unsigned q[$];
  bit m_ovr = 0, m_ferr = 0;
  uart_rx_mmio #(.CLKS_PER_BIT(8), .FIFO_DEPTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .SerialIn(SerialIn), .rdEn(rdEn), .wrtEn(wrtEn),
    .addr(addr), .WrData(WrData), .ReadReg(ReadReg), .rx_irq(rx_irq)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] exp_status();
    return {23'b0, 5'(q.size()), m_ferr, m_ovr, q.size() == 8, q.size() != 0};
  endfunction
  task automatic peek_status(string tag);
    addr = 1'b1;
    #1 check(tag, ReadReg, exp_status());
  endtask
  task automatic rd_status(string tag);
    addr = 1'b1;
    rdEn = 1'b1;
    #1 check(tag, ReadReg, exp_status());
    @(negedge clk);
    rdEn = 1'b0;
  endtask
  task automatic rd_data(string tag);
    logic [31:0] exp;
    exp = q.size() != 0 ? 32'(q.pop_front()) : 32'h0;
    addr = 1'b0;
    rdEn = 1'b1;
    #1 check(tag, ReadReg, exp);
    @(negedge clk);
    rdEn = 1'b0;
  endtask
  task automatic wr_reg(logic a, logic [31:0] d);
    addr = a;
    WrData = d;
    wrtEn = 1'b1;
    @(negedge clk);
    wrtEn = 1'b0;
    if (a) begin
      if (d[2]) m_ovr = 0;
      if (d[3]) m_ferr = 0;
    end
  endtask
  // hook 1 reads RXDATA and hook 2 clears overrun, both on the edge that pushes the byte
  task automatic send_frame(byte unsigned d, bit stop_ok, int hook);
    logic [9:0] f;
    f = {stop_ok, d, 1'b0};
    for (int i = 0; i < 9; i++) begin
      SerialIn = f[i];
      repeat (8) @(negedge clk);
    end
    SerialIn = f[9];
    repeat (7) @(negedge clk);
    #1 check("irq_before_push", rx_irq, q.size() != 0);
    if (!stop_ok) m_ferr = 1;
    if (hook == 1) begin
      addr = 1'b0;
      rdEn = 1'b1;
      #1 check("read_at_push", ReadReg, q.size() != 0 ? 32'(q[0]) : 32'h0);
    end
    if (hook == 2) begin
      addr = 1'b1;
      WrData = 32'h4;
      wrtEn = 1'b1;
    end
    @(negedge clk);
    rdEn = 1'b0;
    wrtEn = 1'b0;
    if (hook == 1 && q.size() != 0) void'(q.pop_front());
    if (hook == 2) m_ovr = 0;
    if (stop_ok) begin
      if (q.size() < 8) q.push_back(d);
      else m_ovr = 1;
    end
    #1 check("irq_after_push", rx_irq, q.size() != 0);
    SerialIn = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic drain(string tag);
    while (q.size() != 0) rd_data(tag);
    rd_data({tag, "_empty"});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("reset_irq", rx_irq, 1'b0);
    peek_status("reset_status");
    rst = 1'b1;
    @(negedge clk);
    rd_data("empty_read");
    rd_status("empty_status");
    send_frame(8'hA5, 1, 0);
    addr = 1'b1;
    #1 check("a5_status_const", ReadReg, 32'h11);
    rd_status("a5_status");
    rd_data("a5_data");
    rd_status("a5_status_after");
    for (int i = 1; i <= 9; i++) send_frame(byte'(i), 1, 0);
    addr = 1'b1;
    #1 check("overrun_status_const", ReadReg, 32'h87);
    for (int i = 0; i < 8; i++) rd_data("fifo_order");
    wr_reg(1'b1, 32'h4);
    rd_status("overrun_cleared");
    send_frame(8'h3C, 0, 0);
    addr = 1'b1;
    #1 check("ferr_bit", ReadReg[3], 1'b1);
    rd_data("ferr_no_push");
    wr_reg(1'b1, 32'h8);
    rd_status("ferr_cleared");
    SerialIn = 1'b0;
    repeat (3) @(negedge clk);
    SerialIn = 1'b1;
    repeat (16) @(negedge clk);
    peek_status("glitch_status");
    check("glitch_irq", rx_irq, 1'b0);
    for (int i = 0; i < 8; i++) send_frame(byte'($urandom), 1, 0);
    send_frame(8'h77, 1, 1);
    rd_status("full_rw_status");
    drain("full_rw_drain");
    for (int i = 0; i < 8; i++) send_frame(byte'($urandom), 1, 0);
    send_frame(8'hE1, 1, 2);
    rd_status("set_wins_status");
    wr_reg(1'b0, 32'hC);
    rd_status("rxdata_write_ignored");
    wr_reg(1'b1, 32'h4);
    drain("set_wins_drain");
    send_frame(8'h96, 1, 1);
    rd_status("empty_rw_status");
    drain("empty_rw_drain");
    send_frame(8'h11, 1, 0);
    SerialIn = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      SerialIn = i[0];
      repeat (8) @(negedge clk);
    end
    SerialIn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_ovr = 0;
    m_ferr = 0;
    repeat (16) @(negedge clk);
    rd_status("post_reset_status");
    send_frame(8'h5A, 1, 0);
    rd_status("post_reset_5a_status");
    drain("post_reset_drain");
    for (int n = 0; n < 14; n++) begin
      send_frame(byte'($urandom), $urandom_range(0, 7) != 0, int'($urandom_range(0, 2)));
      rd_status("rand_status");
      for (int r = $urandom_range(0, 2); r > 0; r--) rd_data("rand_data");
      if ($urandom_range(0, 3) == 0) wr_reg(1'b1, 32'hC);
    end
    drain("rand_drain");
    rd_status("final_status");
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_mmio.md
UART_RX_MMIO -- requirements
Module: uart_rx_mmio

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, receive FIFO entries; power of two, 2..16.
REQ-003 Parameter DATA_WIDTH, default 32, bus read/write data width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on clk rising edge.
REQ-006 SerialIn  input  1  asynchronous UART line; idle high, 8N1 framing, LSB first.
REQ-007 rdEn  input  1  bus read strobe for this peripheral, one cycle per access.
REQ-008 wrtEn  input  1  bus write strobe for this peripheral, one cycle per access.
REQ-009 addr  input  1  register select: 0 = RXDATA, 1 = STATUS.
REQ-010 WrData  input  DATA_WIDTH  bus write data; only STATUS bits [3:2] are used.
REQ-011 ReadReg  output  DATA_WIDTH  combinational read data for the selected register.
REQ-012 rx_irq  output  1  high while FIFO is non-empty.

Function
REQ-013 SerialIn SHALL pass through a 2-flop synchronizer before use; both flops SHALL reset to 1.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA, STOP; a 16-bit baud counter and a 3-bit bit index SHALL drive it.
REQ-015 IDLE: a synchronized 0 SHALL enter START with the baud counter cleared.
REQ-016 START: at count CLKS_PER_BIT/2-1, line 0 -> DATA with counter cleared; line 1 -> IDLE (glitch rejected, nothing recorded).
REQ-017 DATA: each time the count reaches CLKS_PER_BIT-1, the line SHALL be sampled into bit[index]; after index 7 -> STOP.
REQ-018 STOP: at count CLKS_PER_BIT-1, line 1 -> push byte; line 0 -> set frame_err, discard byte; both -> IDLE.
REQ-019 A push SHALL occur exactly one cycle after the stop-bit sample.
REQ-020 A push into a full FIFO SHALL discard the byte and set overrun; FIFO contents SHALL remain unchanged.
REQ-021 FIFO: wrap-around read/write pointers plus a count field of width log2(FIFO_DEPTH)+1.
REQ-022 RXDATA read (rdEn=1, addr=0): ReadReg = {zeros, head byte}; head SHALL pop at the same clk edge.
REQ-023 RXDATA read while empty SHALL return 0 and SHALL leave pointers unchanged.
REQ-024 Simultaneous push and pop when full SHALL perform both with count unchanged and no overrun.
REQ-025 Simultaneous push and pop when empty SHALL return 0 on the read, complete the push, and set count to 1.
REQ-026 STATUS read layout: [0] not-empty, [1] full, [2] overrun, [3] frame_err, [8:4] count, rest 0; the read SHALL have no side effects.
REQ-027 STATUS write (wrtEn=1, addr=1): WrData[2]=1 clears overrun and WrData[3]=1 clears frame_err (write-1-to-clear); writes to RXDATA SHALL be ignored.
REQ-028 A set event and a clear on the same edge SHALL leave the flag set.
REQ-029 When neither strobe is active, ReadReg SHALL still reflect the addressed register combinationally.

Reset
REQ-030 On rst=0 at a clk edge: FSM to IDLE; counters, pointers, count, overrun and frame_err to 0; rx_irq=0; synchronizer flops to 1.
REQ-031 Reset mid-frame SHALL abort the frame with no push; reception SHALL resume on the next falling edge after rst=1.
REQ-032 FIFO data storage SHALL NOT be required to reset.

Verification
REQ-033 CLKS_PER_BIT=8: send 0xA5 -> rx_irq rises 1 cycle after the stop sample; STATUS=0x11; RXDATA read returns 0xA5; STATUS then reads 0x00.
REQ-034 Send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 and no reads -> STATUS=0x87; eight reads return 0x01..0x08; write 0x4 to STATUS -> overrun cleared.
REQ-035 Send 0x3C with the stop bit driven 0 -> no push; STATUS[3]=1; write 0x8 -> STATUS=0x00.
REQ-036 Drive a 3-cycle low pulse on SerialIn -> FSM back in IDLE; count stays 0; no flags set.
REQ-037 FIFO full, then an RXDATA read coincides with a push of 0x77 -> count stays 8, overrun=0, and 0x77 is read last.
REQ-038 Assert rst during DATA bit 4 of a frame, release it, then send 0x5A -> only 0x5A is received.
